// File: rtl/spi_peripheral_rw.sv
// SPI mode-0 peripheral with a read/write register file, per-write strobe and short-frame abort.
// Optional build macro SPI_PERIPH_ERRCNT_EN adds a saturating abort counter readable at address NUM_REGS.
module spi_peripheral_rw #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  FRAME_FULL = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [SYNC_STAGES-1:0]        r_sclk_sync;
  logic [SYNC_STAGES-1:0]        r_ncs_sync;
  logic [SYNC_STAGES-1:0]        r_copi_sync;
  logic [FRAME_W-1:0]            r_shift;
  logic [CNT_W-1:0]              r_bit_cnt;
  logic [ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]             r_rd_shift;
  logic                          r_cipo;
  logic                          r_cipo_oe;
  logic                          r_wr_strobe;
  logic [ADDR_W-1:0]             r_wr_addr;
  logic                          r_frame_err;
  logic [NUM_REGS*DATA_W-1:0]    r_regs;

  logic                          w_sclk_rise;
  logic                          w_sclk_fall;
  logic                          w_ncs_rise;
  logic                          w_ncs_fall;
  logic                          w_copi;
  logic [FRAME_W-1:0]            w_shift_next;
  logic [ADDR_W-1:0]             w_cmd_addr;
  logic                          w_cmd_rw;
  logic                          w_addr_in_range;
  logic [DATA_W-1:0]             w_rd_load;
  logic                          w_abort;
  logic                          w_frame_end;
  logic                          w_commit;
  logic                          w_oe_next;
  logic                          w_unused_shift_msb;

  function automatic logic [DATA_W-1:0] f_reg_sel(
    input logic [NUM_REGS*DATA_W-1:0] regs,
    input logic [ADDR_W-1:0]          addr
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr == ADDR_W'(k)) begin
        v = regs[k*DATA_W +: DATA_W];
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  // Synchronise the SPI pins into the clk domain; index 0 is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '0;
      r_copi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
    end
  end

  assign w_sclk_rise  =  r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_fall  = ~r_sclk_sync[SYNC_STAGES-2] &  r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_rise   =  r_ncs_sync[SYNC_STAGES-2]  & ~r_ncs_sync[SYNC_STAGES-1];
  assign w_ncs_fall   = ~r_ncs_sync[SYNC_STAGES-2]  &  r_ncs_sync[SYNC_STAGES-1];
  assign w_copi       =  r_copi_sync[SYNC_STAGES-1];

  assign w_shift_next       = {r_shift[FRAME_W-2:0], w_copi};
  assign w_cmd_addr         = w_shift_next[ADDR_W-1:0];
  assign w_cmd_rw           = w_shift_next[ADDR_W];
  assign w_addr_in_range    = ({1'b0, r_addr} < NUM_REGS_L);
  assign w_unused_shift_msb = r_shift[FRAME_W-1];

`ifdef SPI_PERIPH_ERRCNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_clr;

  assign w_err_clr = w_frame_end & ({1'b0, r_addr} == NUM_REGS_L);
  assign w_rd_load = ({1'b0, w_cmd_addr} == NUM_REGS_L) ? DATA_W'(r_err_cnt)
                                                        : f_reg_sel(r_regs, w_cmd_addr);

  // Abort counter: cleared by a write to its address, otherwise saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_clr) begin
      r_err_cnt <= 8'd0;
    end else if (w_abort && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end
`else
  assign w_rd_load = f_reg_sel(r_regs, w_cmd_addr);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ncs_fall) w_state_next = S_CMD;
        else            w_state_next = S_IDLE;
      end
      S_CMD: begin
        if (w_ncs_rise)                                 w_state_next = S_IDLE;
        else if (w_sclk_rise && (r_bit_cnt == CMD_LAST)) w_state_next = w_cmd_rw ? S_WDATA : S_RDATA;
        else                                            w_state_next = S_CMD;
      end
      S_WDATA: begin
        if (w_ncs_rise)                    w_state_next = S_IDLE;
        else if (r_bit_cnt == FRAME_FULL)  w_state_next = S_DONE;
        else                               w_state_next = S_WDATA;
      end
      S_RDATA: begin
        if (w_ncs_rise)                                   w_state_next = S_IDLE;
        else if (w_sclk_rise && (r_bit_cnt == FRAME_LAST)) w_state_next = S_DONE;
        else                                              w_state_next = S_RDATA;
      end
      S_DONE: begin
        if (w_ncs_rise) w_state_next = S_IDLE;
        else            w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: abort and write-commit decisions, pad enable.
  always_comb begin
    w_abort     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_CMD, S_RDATA: begin
        w_abort     = w_ncs_rise;
        w_frame_end = 1'b0;
      end
      S_WDATA: begin
        w_abort     = w_ncs_rise;
        w_frame_end = ~w_ncs_rise & (r_bit_cnt == FRAME_FULL);
      end
      default: begin
        w_abort     = 1'b0;
        w_frame_end = 1'b0;
      end
    endcase
    w_commit  = w_frame_end & w_addr_in_range;
    w_oe_next = (w_state_next != S_IDLE);
  end

  // Frame shifting, bit counting and the CIPO read shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_addr     <= '0;
      r_rd_shift <= '0;
      r_cipo     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_shift    <= '0;
          r_bit_cnt  <= '0;
          r_rd_shift <= '0;
          r_cipo     <= 1'b0;
        end
        S_CMD: begin
          if (w_sclk_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
            if (r_bit_cnt == CMD_LAST) begin
              r_addr     <= w_cmd_addr;
              r_rd_shift <= w_rd_load;
            end
          end
        end
        S_WDATA: begin
          if (w_sclk_rise && (r_bit_cnt != FRAME_FULL)) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_RDATA: begin
          if (w_sclk_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
          if (w_sclk_fall) begin
            r_cipo     <= r_rd_shift[DATA_W-1];
            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
      if (w_state_next == S_IDLE) begin
        r_cipo <= 1'b0;
      end
    end
  end

  // Register file commit and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cipo_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      r_regs      <= '0;
    end else begin
      r_cipo_oe   <= w_oe_next;
      r_wr_strobe <= w_commit;
      r_frame_err <= w_abort;
      if (w_commit) begin
        r_wr_addr <= r_addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (r_addr == ADDR_W'(k)) begin
            r_regs[k*DATA_W +: DATA_W] <= r_shift[DATA_W-1:0];
          end
        end
      end
    end
  end

  assign CIPO      = r_cipo;
  assign cipo_oe   = r_cipo_oe;
  assign regs_out  = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_peripheral_rw.sv
// Self-checking bench for spi_peripheral_rw: directed frames plus randomized frames against a frame-level model.
module tb_spi_peripheral_rw;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int HALF     = 6;
`ifdef SPI_PERIPH_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SCLK  = 1'b0;
  logic nCS   = 1'b1;
  logic COPI  = 1'b0;
  logic                       CIPO;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;

  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;
  int ferr_seen = 0;

  logic [7:0] m_regs [NUM_REGS];
  int         m_errcnt;
  logic [6:0] m_wr_addr;

  spi_peripheral_rw dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SCLK      (SCLK),
    .nCS       (nCS),
    .COPI      (COPI),
    .CIPO      (CIPO),
    .cipo_oe   (cipo_oe),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_seen++;
    if (frame_err === 1'b1) ferr_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = m_regs[k];
    return f;
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) if (int'(a) == k) v = m_regs[k];
    if (ERRCNT && int'(a) == NUM_REGS) v = 8'(m_errcnt);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
    m_errcnt  = 0;
    m_wr_addr = 7'h00;
  endtask

  // Drives one frame of nbits SCLK pulses; collects CIPO at the data-phase rising edges.
  task automatic spi_frame(input logic [15:0] word, input int nbits,
                           output logic [7:0] rd, output logic oe_mid);
    rd     = 8'h00;
    oe_mid = 1'b0;
    nCS = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      COPI = (i < 16) ? word[15-i] : 1'($urandom_range(1, 0));
      wait_clk(HALF);
      if (i >= 8 && i < 16) rd = {rd[6:0], CIPO};
      if (i == 8) oe_mid = cipo_oe;
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    wait_clk(HALF);
    nCS = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_frame(input logic [15:0] word, input int nbits, input string tag);
    int         s0, e0, exp_s, exp_e;
    logic [7:0] rd, exp_rd;
    logic       oe_mid;
    logic [6:0] a;
    s0 = strobe_seen;
    e0 = ferr_seen;
    exp_s = 0;
    exp_e = 0;
    a = word[14:8];
    exp_rd = model_read(a);
    spi_frame(word, nbits, rd, oe_mid);
    if (nbits < 16) begin
      exp_e = 1;
      if (m_errcnt < 255) m_errcnt++;
    end else if (word[15]) begin
      if (int'(a) < NUM_REGS) begin
        m_regs[int'(a)] = word[7:0];
        m_wr_addr = a;
        exp_s = 1;
      end else if (ERRCNT && int'(a) == NUM_REGS) begin
        m_errcnt = 0;
      end
    end
    check({tag, "_regs"}, 64'(regs_out), 64'(model_flat()));
    check({tag, "_strobes"}, 64'(strobe_seen - s0), 64'(exp_s));
    check({tag, "_frame_err"}, 64'(ferr_seen - e0), 64'(exp_e));
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    check({tag, "_oe_idle"}, 64'({cipo_oe, CIPO}), 64'(0));
    if (nbits > 8) check({tag, "_oe_mid"}, 64'(oe_mid), 64'(1));
    if (nbits >= 16 && !word[15]) check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
  endtask

  initial begin
    logic [15:0] w;
    int          nb, r;
    int          s0, e0;
    model_reset();

    wait_clk(3);
    check("reset_regs", 64'(regs_out), 64'(0));
    check("reset_pins", 64'({CIPO, cipo_oe, wr_strobe, frame_err}), 64'(0));
    check("reset_wr_addr", 64'(wr_addr), 64'(0));
    rst_n = 1'b1;
    wait_clk(10);
    check("idle_after_reset", 64'({CIPO, cipo_oe, wr_strobe, frame_err}), 64'(0));

    do_frame(16'h80A5, 16, "wr_reg0");
    do_frame(16'h843C, 16, "wr_reg4");
    do_frame(16'h0400, 16, "rd_reg4");
    do_frame(16'hFFFF, 16, "wr_oob");
    do_frame(16'h7F00, 16, "rd_oob");
    do_frame(16'h81FF, 10, "abort_wr1");
    do_frame(16'h8112, 16, "wr_reg1");
    do_frame(16'h820F, 20, "long_wr2");
    do_frame(16'h0200, 16, "rd_reg2");

    // Asynchronous reset in the middle of a write frame; the tail must be ignored.
    s0 = strobe_seen;
    e0 = ferr_seen;
    nCS = 1'b0;
    wait_clk(HALF);
    w = 16'h8377;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        rst_n = 1'b0;
        wait_clk(1);
        check("midrst_regs", 64'(regs_out), 64'(0));
        check("midrst_pins", 64'({CIPO, cipo_oe, wr_addr}), 64'(0));
        rst_n = 1'b1;
      end
      COPI = w[15-i];
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    wait_clk(HALF);
    nCS = 1'b1;
    wait_clk(8);
    model_reset();
    check("midrst_tail_regs", 64'(regs_out), 64'(0));
    check("midrst_tail_pulses", 64'({strobe_seen - s0, ferr_seen - e0}), 64'(0));

    do_frame(16'h8100, 4, "abort_a");
    do_frame(16'h0000, 12, "abort_b");
    do_frame(16'h8300, 9, "abort_c");
    do_frame(16'h0500, 16, "rd_addr5");
    do_frame(16'h8566, 16, "wr_addr5");
    do_frame(16'h0500, 16, "rd_addr5_again");

    for (int n = 0; n < 110; n++) begin
      w[15]   = 1'($urandom_range(1, 0));
      w[14:8] = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'($urandom_range(7, 0));
      w[7:0]  = 8'($urandom);
      r = $urandom_range(9, 0);
      if (r == 0)      nb = $urandom_range(15, 1);
      else if (r == 1) nb = $urandom_range(20, 17);
      else             nb = 16;
      do_frame(w, nb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_peripheral_rw.md
Name: spi_peripheral_rw

Overview:
- Parametrised successor to the team's write-only SPI register block: SPI mode-0 peripheral with a configurable register file.
- Adds read-back on CIPO, a per-write strobe, and abort handling for short frames.
- Sits between the chip-level SPI pins and the PWM/output-enable logic; all register outputs are in the clk domain.

Parameters:
- ADDR_W, 7: address field width in bits.
- DATA_W, 8: data field width and register width in bits.
- NUM_REGS, 5: number of implemented registers, at addresses 0..NUM_REGS-1 (NUM_REGS ≤ 2^ADDR_W).
- SYNC_STAGES, 2: synchroniser depth for SCLK, nCS and COPI (≥2).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- SCLK, input, 1: SPI clock, idle low.
- nCS, input, 1: chip select, active low.
- COPI, input, 1: controller-out data.
- CIPO, output, 1: peripheral-out data.
- cipo_oe, output, 1: CIPO output enable for the pad.
- regs_out, output, NUM_REGS*DATA_W: flat register file; register k occupies bits [k*DATA_W +: DATA_W].
- wr_strobe, output, 1: one-cycle pulse when a register is written.
- wr_addr, output, ADDR_W: address of the most recent write.
- frame_err, output, 1: one-cycle pulse when a frame aborts short.

Behaviour:
- Frame format: 1+ADDR_W+DATA_W bits (16 at defaults), MSB first: R/W bit (1=write, 0=read), then address, then data.
- COPI is sampled on SCLK rising edges. CIPO changes on SCLK falling edges.
- All three SPI inputs pass through SYNC_STAGES flops. Edges are detected on the last two synced stages.
- Maximum SCLK frequency is clk/8.
- Reset values: regs_out=0, CIPO=0, cipo_oe=0, wr_strobe=0, wr_addr=0, frame_err=0, FSM=IDLE, bit counter=0, shift register=0.
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE → CMD on synced nCS falling edge; bit counter and shift register clear.
- CMD: shift in the R/W bit and ADDR_W address bits.
  - After the last address bit: R/W=1 → WDATA; R/W=0 → RDATA.
  - On entry to RDATA, load the read shifter with register[addr], or 0 if addr ≥ NUM_REGS.
- RDATA:
  - On each SCLK falling edge, CIPO takes the next read-shifter bit, MSB first.
  - The first falling edge after the last address bit drives data MSB.
  - COPI bits are still counted. Reaching a full count → DONE.
- WDATA: shift in DATA_W bits. On the clk cycle after the final bit is captured:
  - if addr < NUM_REGS, update the register, pulse wr_strobe, and update wr_addr in that same cycle;
  - if addr ≥ NUM_REGS, silently ignore (no strobe, no error);
  - then → DONE.
- DONE: ignore further SCLK edges; → IDLE on synced nCS rising edge.
- cipo_oe = 1 while FSM is in CMD, WDATA, RDATA or DONE; otherwise 0. CIPO = 0 whenever cipo_oe = 0.
- Abort: synced nCS rises in CMD, WDATA or RDATA → discard the partial frame, no register change, pulse frame_err for one cycle, → IDLE.
- nCS falling and rising edges are never both detected in one cycle. A new nCS falling edge while in DONE cannot occur, because nCS must rise first.
- Write commit and a read in a later frame of the same address: the read returns the new value.
- Asynchronous reset mid-frame returns everything to reset values immediately. The remainder of that frame is ignored until the next nCS falling edge.

Optional Feature:
- SPI_PERIPH_ERRCNT_EN defined: adds an 8-bit saturating abort counter, read-only at address NUM_REGS.
  - The counter increments on each frame_err pulse and saturates at 255.
  - A write to address NUM_REGS clears the counter to 0 and does not pulse wr_strobe.
- Undefined: no counter; address NUM_REGS behaves as any out-of-range address.

Test Plan:
- Write 0x80_A5 (reg 0 ← 0xA5) → regs_out[7:0]=0xA5, one wr_strobe, wr_addr=0, other registers still 0.
- Write reg 4 ← 0x3C, then read frame 0x04_xx → CIPO shifts 0,0,1,1,1,1,0,0 on data-phase falling edges; cipo_oe=1 only while nCS is low.
- Write to address 0x7F (value 0xFF) → no register change, no wr_strobe, no frame_err; a subsequent read of 0x7F returns 0x00.
- Raise nCS after 10 bits of write 0x81_FF → reg 1 unchanged (0x00), one frame_err pulse; the next full frame 0x81_12 sets reg 1=0x12.
- Send 20 SCLK pulses with frame 0x82_0F → reg 2=0x0F, exactly one wr_strobe, extra bits ignored.
- With SPI_PERIPH_ERRCNT_EN: three aborted frames then read address 5 → 0x03; write to address 5 → a later read returns 0x00.
